mult_result_fifo: RTL and testbench
===================================

# mult_result_fifo

Output-side buffering stage placed directly downstream of the combinational FP32 multiplier (Mult_precise). It captures each product word together with its Exception/Overflow/Underflow flags under a valid/ready handshake and holds them in a small FIFO until the consumer takes them. It also keeps sticky status flags and saturating per-flag event counters for software/debug. This decouples the multiplier's combinational result from a stalling consumer.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  multiplier result presented
- in_ready  out  1  stage can accept; = (level < DEPTH)
- in_result  in  32  product word {sign, exp[7:0], mant[22:0]}
- in_exception  in  1  multiplier Exception flag
- in_overflow  in  1  multiplier Overflow flag
- in_underflow  in  1  multiplier Underflow flag
- out_valid  out  1  head entry available; = (level != 0)
- out_ready  in  1  consumer takes head
- out_result  out  32  head product word; 0 when empty
- out_flags  out  3  head {exception, overflow, underflow}; 0 when empty
- level  out  $clog2(DEPTH)+1  current occupancy
- sticky_flags  out  3  OR of all accepted {exc, ovf, unf} since reset/clear
- exc_count, ovf_count, unf_count  out  CNT_W each  accepted entries with that flag set
- clr_stat  in  1  synchronous clear of sticky_flags and counters

## Operation
- Push = in_valid & in_ready; writes {flags, result} at wr_ptr, wr_ptr++ mod DEPTH.
- Pop = out_valid & out_ready; rd_ptr++ mod DEPTH.
- level: +1 on push only, −1 on pop only, unchanged on both or neither.
- in_ready depends only on level (no combinational path from out_ready); when full, a same-cycle pop does not enable a push.
- out_result/out_flags: combinational read of entry at rd_ptr, forced 0 when level==0.
- Entries stored verbatim; no reinterpretation of flags or result (NaN/zero encodings passed through).
- Sticky: on push, sticky_flags |= pushed flags.
- Counters: on push, each counter whose flag is set increments; saturates at 2^CNT_W−1 (no wrap).
- clr_stat: sticky_flags and counters → 0 next edge. If clr_stat coincides with a flagged push, push wins: sticky bit = 1, counter = 1.
- in_valid while in_ready=0: ignored, no state change; upstream must hold.
- Pointers wrap silently; full detected by level==DEPTH, empty by level==0.

## Timing
- Reset (rst_n=0, asynchronous): pointers, level, sticky_flags, counters = 0; in_ready=1, out_valid=0, out_result=0, out_flags=0. Storage array contents need not reset. Reset mid-operation discards all entries immediately.
- Latency: word pushed at edge k is visible on out_result with out_valid=1 after edge k (usable in cycle k+1) if FIFO was empty; otherwise after all earlier entries popped.
- Throughput: one push and one pop per cycle sustained when 0 < level < DEPTH.
- Counters/sticky update on the same edge as the push.
- Handshake: out_result/out_flags stable while out_valid=1 and out_ready=0.

## Test plan
- Reset: assert rst_n=0 mid-stream with level=3 → level=0, out_valid=0, out_result=0, in_ready=1, counters 0 immediately.
- Single pass: push 0x40C00000 (flags 000) into empty FIFO, out_ready=1 → next cycle out_valid=1, out_result=0x40C00000, out_flags=000; following cycle level=0.
- Fill/backpressure: out_ready=0, push 5 words with DEPTH=4 → in_ready=0 after 4th; 5th held; level=4; drain yields words 1–4 in order, then 5th accepted.
- Flags: push 0x7F800000 flags 100, 0x7F800000 flags 010, 0x80000000 flags 001 → sticky_flags=111, exc=ovf=unf=1; out_flags match per entry.
- Simultaneous push/pop at level=2 for 10 cycles → level stays 2, order preserved across pointer wrap.
- clr_stat coincident with flagged push (flags 010) → sticky_flags=010, ovf_count=1, others 0; with CNT_W=2, four further ovf pushes → ovf_count holds 3.

Source files
------------

// File: rtl/mult_result_fifo.sv
// Result buffer behind the FP32 multiplier: queues {flags, product} words under
// valid/ready and keeps sticky flag status plus saturating per-flag event counters.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready depends only on occupancy, and out_valid/out_result/out_flags depend only
// on stored state. The producer must hold its word while in_ready is 0. The head
// word stays stable while the consumer stalls.
module mult_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic                       in_exception,
    input  logic                       in_overflow,
    input  logic                       in_underflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic [2:0]                 sticky_flags,
    output logic [CNT_W-1:0]           exc_count,
    output logic [CNT_W-1:0]           ovf_count,
    output logic [CNT_W-1:0]           unf_count,
    input  logic                       clr_stat
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [34:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [2:0]       r_sticky;
    logic [CNT_W-1:0] r_exc_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;
    logic [CNT_W-1:0] r_unf_cnt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [2:0]       w_in_flags;
    logic [34:0]      w_head;

    // Clearing happens first so a coincident flagged push still counts as one event.
    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] cur,
        input logic             clr,
        input logic             hit
    );
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (hit && (base != {CNT_W{1'b1}})) begin
            base = base + 1'b1;
        end
        return base;
    endfunction

    assign w_in_flags  = {in_exception, in_overflow, in_underflow};
    assign w_in_ready  = (r_level != FULL_LEVEL);
    assign w_out_valid = (r_level != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage is not reset; the level counter alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_in_flags, in_result};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky  <= '0;
            r_exc_cnt <= '0;
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else begin
            r_sticky  <= (clr_stat ? 3'b000 : r_sticky) | (w_push ? w_in_flags : 3'b000);
            r_exc_cnt <= next_cnt(r_exc_cnt, clr_stat, w_push & in_exception);
            r_ovf_cnt <= next_cnt(r_ovf_cnt, clr_stat, w_push & in_overflow);
            r_unf_cnt <= next_cnt(r_unf_cnt, clr_stat, w_push & in_underflow);
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_result   = w_out_valid ? w_head[31:0]  : 32'h0;
    assign out_flags    = w_out_valid ? w_head[34:32] : 3'b000;
    assign level        = r_level;
    assign sticky_flags = r_sticky;
    assign exc_count    = r_exc_cnt;
    assign ovf_count    = r_ovf_cnt;
    assign unf_count    = r_unf_cnt;

endmodule

// File: tb/tb_mult_result_fifo.sv
// Bench for mult_result_fifo: two instances (16-bit and 2-bit counters) share one
// directed stimulus and are checked every cycle against a queue-based model.
module tb_mult_result_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_result = '0;
    logic        in_exception = 1'b0;
    logic        in_overflow = 1'b0;
    logic        in_underflow = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_stat = 1'b0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_result_a, out_result_b;
    logic [2:0]  out_flags_a, out_flags_b, sticky_a, sticky_b;
    logic [2:0]  level_a, level_b;
    logic [15:0] exc_a, ovf_a, unf_a;
    logic [1:0]  exc_b, ovf_b, unf_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [34:0] exp_q[$];
    logic [2:0]  m_sticky;
    int          m_cnt_a[3];
    int          m_cnt_b[3];

    mult_result_fifo #(.DEPTH(DEPTH), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_result(in_result),
        .in_exception(in_exception), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_result(out_result_a),
        .out_flags(out_flags_a), .level(level_a), .sticky_flags(sticky_a),
        .exc_count(exc_a), .ovf_count(ovf_a), .unf_count(unf_a), .clr_stat(clr_stat)
    );

    mult_result_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_result(in_result),
        .in_exception(in_exception), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_result(out_result_b),
        .out_flags(out_flags_b), .level(level_b), .sticky_flags(sticky_b),
        .exc_count(exc_b), .ovf_count(ovf_b), .unf_count(unf_b), .clr_stat(clr_stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of {flags, result}, counters as plain integers with a ceiling.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_sticky = 3'b000;
            for (int i = 0; i < 3; i++) begin
                m_cnt_a[i] = 0;
                m_cnt_b[i] = 0;
            end
        end else begin
            automatic bit do_push = in_valid && (exp_q.size() < DEPTH);
            automatic bit do_pop  = out_ready && (exp_q.size() > 0);
            automatic logic [2:0] fl = {in_exception, in_overflow, in_underflow};
            if (clr_stat) begin
                m_sticky = 3'b000;
                for (int i = 0; i < 3; i++) begin
                    m_cnt_a[i] = 0;
                    m_cnt_b[i] = 0;
                end
            end
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back({fl, in_result});
                m_sticky = m_sticky | fl;
                for (int i = 0; i < 3; i++) begin
                    if (fl[2-i]) begin
                        if (m_cnt_a[i] < 65535) m_cnt_a[i]++;
                        if (m_cnt_b[i] < 3) m_cnt_b[i]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        automatic int       sz   = exp_q.size();
        automatic logic [34:0] head = (sz > 0) ? exp_q[0] : 35'h0;
        chk("in_ready_a", 32'(in_ready_a), 32'(sz < DEPTH));
        chk("in_ready_b", 32'(in_ready_b), 32'(sz < DEPTH));
        chk("out_valid_a", 32'(out_valid_a), 32'(sz != 0));
        chk("out_valid_b", 32'(out_valid_b), 32'(sz != 0));
        chk("out_result_a", out_result_a, head[31:0]);
        chk("out_result_b", out_result_b, head[31:0]);
        chk("out_flags_a", 32'(out_flags_a), 32'(head[34:32]));
        chk("out_flags_b", 32'(out_flags_b), 32'(head[34:32]));
        chk("level_a", 32'(level_a), 32'(sz));
        chk("level_b", 32'(level_b), 32'(sz));
        chk("sticky_a", 32'(sticky_a), 32'(m_sticky));
        chk("sticky_b", 32'(sticky_b), 32'(m_sticky));
        chk("exc_a", 32'(exc_a), 32'(m_cnt_a[0]));
        chk("ovf_a", 32'(ovf_a), 32'(m_cnt_a[1]));
        chk("unf_a", 32'(unf_a), 32'(m_cnt_a[2]));
        chk("exc_b", 32'(exc_b), 32'(m_cnt_b[0]));
        chk("ovf_b", 32'(ovf_b), 32'(m_cnt_b[1]));
        chk("unf_b", 32'(unf_b), 32'(m_cnt_b[2]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] f);
        in_valid     = v;
        in_result    = r;
        in_exception = f[2];
        in_overflow  = f[1];
        in_underflow = f[0];
    endtask

    logic [31:0] fill_words[5];

    initial begin
        fill_words[0] = 32'h3F800000;
        fill_words[1] = 32'h40000000;
        fill_words[2] = 32'hC0400000;
        fill_words[3] = 32'h7FC00000;
        fill_words[4] = 32'h00000000;

        repeat (3) step();
        rst_n = 1'b1;
        chk("reset_level", 32'(level_a), 32'd0);
        chk("reset_in_ready", 32'(in_ready_a), 32'd1);
        chk("reset_out_result", out_result_a, 32'd0);

        // Single pass through an empty FIFO.
        out_ready = 1'b1;
        drive(1'b1, 32'h40C00000, 3'b000);
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("single_valid", 32'(out_valid_a), 32'd1);
        chk("single_result", out_result_a, 32'h40C00000);
        chk("single_flags", 32'(out_flags_a), 32'd0);
        step();
        chk("single_drained", 32'(level_a), 32'd0);

        // Fill past capacity with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, fill_words[i], 3'b000);
            step();
        end
        step();
        chk("fill_level", 32'(level_a), 32'd4);
        chk("fill_in_ready", 32'(in_ready_a), 32'd0);
        chk("fill_head_stable", out_result_a, 32'h3F800000);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_order", out_result_a, fill_words[i]);
            step();
            if (i == 1) drive(1'b0, 32'h0, 3'b000);
        end
        chk("drain_empty", 32'(level_a), 32'd0);

        // Flagged results, including Inf and negative zero passed through verbatim.
        out_ready = 1'b0;
        drive(1'b1, 32'h7F800000, 3'b100); step();
        drive(1'b1, 32'h7F800000, 3'b010); step();
        drive(1'b1, 32'h80000000, 3'b001); step();
        drive(1'b0, 32'h0, 3'b000);
        chk("flags_sticky", 32'(sticky_a), 32'h7);
        chk("flags_exc", 32'(exc_a), 32'd1);
        chk("flags_ovf", 32'(ovf_a), 32'd1);
        chk("flags_unf", 32'(unf_a), 32'd1);
        out_ready = 1'b1;
        chk("flags_head0", 32'(out_flags_a), 32'h4); step();
        chk("flags_head1", 32'(out_flags_a), 32'h2); step();
        chk("flags_head2", 32'(out_flags_a), 32'h1);
        chk("flags_res2", out_result_a, 32'h80000000); step();

        // Steady push/pop at level 2 across pointer wrap.
        out_ready = 1'b0;
        drive(1'b1, 32'h11110000, 3'b000); step();
        drive(1'b1, 32'h11110001, 3'b000); step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h22220000 + 32'(i), 3'(i % 8));
            step();
            chk("stream_level", 32'(level_a), 32'd2);
        end
        drive(1'b0, 32'h0, 3'b000);
        chk("stream_head", out_result_a, 32'h22220008);
        step(); step();

        // Clear coinciding with an overflow push, then saturate the 2-bit counter.
        clr_stat = 1'b1;
        drive(1'b1, 32'h7F800000, 3'b010);
        step();
        clr_stat = 1'b0;
        chk("clr_sticky", 32'(sticky_a), 32'h2);
        chk("clr_ovf", 32'(ovf_a), 32'd1);
        chk("clr_exc", 32'(exc_a), 32'd0);
        chk("clr_unf", 32'(unf_a), 32'd0);
        repeat (4) step();
        drive(1'b0, 32'h0, 3'b000);
        chk("sat_ovf_b", 32'(ovf_b), 32'd3);
        chk("sat_ovf_a", 32'(ovf_a), 32'd5);
        step();

        // Asynchronous reset with three entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h33330000 + 32'(i), 3'b111);
            step();
        end
        drive(1'b0, 32'h0, 3'b000);
        chk("pre_reset_level", 32'(level_a), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_level", 32'(level_a), 32'd0);
        chk("areset_valid", 32'(out_valid_a), 32'd0);
        chk("areset_result", out_result_a, 32'd0);
        chk("areset_ready", 32'(in_ready_a), 32'd1);
        chk("areset_exc", 32'(exc_a), 32'd0);
        chk("areset_sticky", 32'(sticky_a), 32'd0);
        step();
        rst_n = 1'b1;
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
